// File: rtl/commit_trace_buffer.sv
// Multi-lane retire trace FIFO feeding a single-record difftest commit port.
// Also keeps the cycle/instruction counters and latches the halt trap.
module commit_trace_buffer #(
    parameter int               CHANNELS  = 2,
    parameter int               DEPTH     = 8,
    parameter int               PC_W      = 32,
    parameter int               REG_AW    = 5,
    parameter logic [PC_W-1:0]  TRAP_INST = 32'h80000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       chip_enable_i,
    input  logic [CHANNELS-1:0]        commit_valid_i,
    input  logic [CHANNELS*PC_W-1:0]   commit_pc_i,
    input  logic [CHANNELS*PC_W-1:0]   commit_instr_i,
    input  logic [CHANNELS-1:0]        commit_wreg_i,
    input  logic [CHANNELS*REG_AW-1:0] commit_waddr_i,
    input  logic [CHANNELS*PC_W-1:0]   commit_wdata_i,
    input  logic [PC_W-1:0]            gpr_a0_i,
    output logic                       stall_o,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    output logic [PC_W-1:0]            out_pc_o,
    output logic [PC_W-1:0]            out_instr_o,
    output logic                       out_wen_o,
    output logic [REG_AW-1:0]          out_wdest_o,
    output logic [PC_W-1:0]            out_wdata_o,
    output logic [7:0]                 out_index_o,
    output logic [63:0]                cycle_cnt_o,
    output logic [63:0]                instr_cnt_o,
    output logic                       trap_valid_o,
    output logic [PC_W-1:0]            trap_code_o,
    output logic [PC_W-1:0]            trap_pc_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CH_C    = CW'(CHANNELS);

    logic [PC_W-1:0]   pc_mem    [DEPTH];
    logic [PC_W-1:0]   instr_mem [DEPTH];
    logic [PC_W-1:0]   wdata_mem [DEPTH];
    logic [REG_AW-1:0] wdest_mem [DEPTH];
    logic              wen_mem   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [7:0]    index_q, index_d;
    logic [63:0]   cycle_q, cycle_d, instr_q, instr_d;
    logic          trap_valid_q, trap_valid_d;
    logic [PC_W-1:0] trap_code_q, trap_code_d, trap_pc_q, trap_pc_d;
    logic          overflow_q, overflow_d;

    logic [CHANNELS-1:0] acc;
    logic [AW-1:0]       lane_off [CHANNELS];
    logic [CW-1:0]       n_cnt;
    logic                pop, fits, push, hit_trap;

    assign out_valid_o = (occ_q != '0);
    assign stall_o     = ((DEPTH_C - {1'b0, occ_q}) < CH_C);

    // Head view is forced to zero when empty so stale slots never leak out.
    assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr_q]    : '0;
    assign out_instr_o = out_valid_o ? instr_mem[rd_ptr_q] : '0;
    assign out_wen_o   = out_valid_o ? wen_mem[rd_ptr_q]   : 1'b0;
    assign out_wdest_o = out_valid_o ? wdest_mem[rd_ptr_q] : '0;
    assign out_wdata_o = out_valid_o ? wdata_mem[rd_ptr_q] : '0;

    assign out_index_o  = index_q;
    assign cycle_cnt_o  = cycle_q;
    assign instr_cnt_o  = instr_q;
    assign trap_valid_o = trap_valid_q;
    assign trap_code_o  = trap_code_q;
    assign trap_pc_o    = trap_pc_q;
    assign overflow_o   = overflow_q;

    always_comb begin
        acc   = commit_valid_i & {CHANNELS{chip_enable_i}};
        n_cnt = '0;
        // Each accepted lane lands at an offset equal to the accepted lanes below it.
        for (int k = 0; k < CHANNELS; k++) begin
            lane_off[k] = n_cnt[AW-1:0];
            n_cnt       = n_cnt + CW'(acc[k]);
        end

        pop      = out_valid_o & out_ready_i;
        fits     = (({1'b0, occ_q} - CW'(pop) + n_cnt) <= DEPTH_C);
        push     = (n_cnt != '0) && !trap_valid_q && fits;
        hit_trap = pop && !trap_valid_q && (instr_mem[rd_ptr_q] == TRAP_INST);

        wr_ptr_d = wr_ptr_q + (push ? n_cnt[AW-1:0] : '0);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        occ_d    = occ_q + (push ? n_cnt[AW:0] : '0) - (AW+1)'(pop);
        index_d  = index_q + 8'(pop);

        cycle_d  = trap_valid_q ? cycle_q : cycle_q + 64'd1;
        instr_d  = (pop && !trap_valid_q) ? instr_q + 64'd1 : instr_q;

        trap_valid_d = trap_valid_q | hit_trap;
        trap_pc_d    = hit_trap ? pc_mem[rd_ptr_q] : trap_pc_q;
        trap_code_d  = hit_trap ? gpr_a0_i : trap_code_q;
        overflow_d   = overflow_q | ((n_cnt != '0) && !trap_valid_q && !fits);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            index_q      <= '0;
            cycle_q      <= '0;
            instr_q      <= '0;
            trap_valid_q <= 1'b0;
            trap_code_q  <= '0;
            trap_pc_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            index_q      <= index_d;
            cycle_q      <= cycle_d;
            instr_q      <= instr_d;
            trap_valid_q <= trap_valid_d;
            trap_code_q  <= trap_code_d;
            trap_pc_q    <= trap_pc_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < CHANNELS; k++) begin
            if (push && acc[k]) begin
                pc_mem[wr_ptr_q + lane_off[k]]    <= commit_pc_i[k*PC_W +: PC_W];
                instr_mem[wr_ptr_q + lane_off[k]] <= commit_instr_i[k*PC_W +: PC_W];
                wdata_mem[wr_ptr_q + lane_off[k]] <= commit_wdata_i[k*PC_W +: PC_W];
                wdest_mem[wr_ptr_q + lane_off[k]] <= commit_waddr_i[k*REG_AW +: REG_AW];
                wen_mem[wr_ptr_q + lane_off[k]]   <= commit_wreg_i[k];
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (CHANNELS=2, DEPTH=8): packing,
// back-pressure, overflow, chip-enable gating, trap capture and async reset.
module tb_commit_trace_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        chip_enable_i;
    logic [1:0]  commit_valid_i;
    logic [63:0] commit_pc_i, commit_instr_i, commit_wdata_i;
    logic [1:0]  commit_wreg_i;
    logic [9:0]  commit_waddr_i;
    logic [31:0] gpr_a0_i;
    logic        stall_o, out_ready_i, out_valid_o, out_wen_o;
    logic [31:0] out_pc_o, out_instr_o, out_wdata_o;
    logic [4:0]  out_wdest_o;
    logic [7:0]  out_index_o;
    logic [63:0] cycle_cnt_o, instr_cnt_o;
    logic        trap_valid_o, overflow_o;
    logic [31:0] trap_code_o, trap_pc_o;

    int          n_vec = 0;
    int          n_err = 0;
    longint      exp_cyc = 0;
    bit          trapped = 1'b0;
    logic [31:0] exp_pc [9];

    always #5 clock = ~clock;

    commit_trace_buffer #(.CHANNELS(2), .DEPTH(8), .PC_W(32), .REG_AW(5),
                          .TRAP_INST(32'h80000000)) dut (
        .clock(clock), .reset(reset), .chip_enable_i(chip_enable_i),
        .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
        .commit_instr_i(commit_instr_i), .commit_wreg_i(commit_wreg_i),
        .commit_waddr_i(commit_waddr_i), .commit_wdata_i(commit_wdata_i),
        .gpr_a0_i(gpr_a0_i), .stall_o(stall_o), .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_instr_o(out_instr_o),
        .out_wen_o(out_wen_o), .out_wdest_o(out_wdest_o), .out_wdata_o(out_wdata_o),
        .out_index_o(out_index_o), .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o),
        .trap_valid_o(trap_valid_o), .trap_code_o(trap_code_o), .trap_pc_o(trap_pc_o),
        .overflow_o(overflow_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane 0 writes a register, lane 1 does not; wdest/wdata derive from the PC.
    task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] i0, input logic [31:0] i1);
        commit_valid_i = v;
        commit_pc_i    = {p1, p0};
        commit_instr_i = {i1, i0};
        commit_wreg_i  = 2'b01;
        commit_waddr_i = {p1[6:2], p0[6:2]};
        commit_wdata_i = {p1 + 32'd1, p0 + 32'd1};
    endtask

    task automatic idle;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic tick;
        if (!reset && !trapped) exp_cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; chip_enable_i = 1'b1; out_ready_i = 1'b0; gpr_a0_i = '0;
        idle();
        #1;
        check("rst_valid", 64'(out_valid_o), 64'h0);
        check("rst_stall", 64'(stall_o), 64'h0);
        check("rst_cycle", cycle_cnt_o, 64'h0);
        check("rst_ovf", 64'(overflow_o), 64'h0);
        tick(); tick();
        reset = 1'b0;
        exp_cyc = 0;

        // two lanes in one cycle, drained in lane order
        out_ready_i = 1'b1;
        drive(2'b11, 32'h1c000000, 32'h1c000004, 32'h00000013, 32'h00000093);
        tick(); idle();
        check("t1_valid", 64'(out_valid_o), 64'h1);
        check("t1_pc0", 64'(out_pc_o), 64'h1c000000);
        check("t1_idx0", 64'(out_index_o), 64'h0);
        check("t1_cycle", cycle_cnt_o, 64'(exp_cyc));
        tick();
        check("t1_pc1", 64'(out_pc_o), 64'h1c000004);
        check("t1_idx1", 64'(out_index_o), 64'h1);
        check("t1_icnt1", instr_cnt_o, 64'h1);
        tick();
        check("t1_empty", 64'(out_valid_o), 64'h0);
        check("t1_icnt2", instr_cnt_o, 64'h2);

        // lane 1 only: single packed record
        out_ready_i = 1'b0;
        drive(2'b10, 32'h0, 32'h1c000010, 32'h0, 32'h00000033);
        tick(); idle();
        check("t2_valid", 64'(out_valid_o), 64'h1);
        check("t2_pc", 64'(out_pc_o), 64'h1c000010);
        check("t2_wen", 64'(out_wen_o), 64'h0);
        check("t2_wdest", 64'(out_wdest_o), 64'h4);
        check("t2_wdata", 64'(out_wdata_o), 64'h1c000011);
        out_ready_i = 1'b1;
        tick();
        check("t2_single", 64'(out_valid_o), 64'h0);
        check("t2_icnt", instr_cnt_o, 64'h3);

        // fill to full, drop a group, then push+pop while full
        out_ready_i = 1'b0;
        for (int g = 0; g < 4; g++) begin
            drive(2'b11, 32'h1c000200 + 32'(8*g), 32'h1c000204 + 32'(8*g), 32'h13, 32'h13);
            tick();
            if (g == 2) check("t3_stall_occ6", 64'(stall_o), 64'h0);
        end
        check("t3_stall_full", 64'(stall_o), 64'h1);
        check("t3_no_ovf", 64'(overflow_o), 64'h0);
        drive(2'b11, 32'h1c000280, 32'h1c000284, 32'h13, 32'h13);
        tick();
        check("t3_ovf", 64'(overflow_o), 64'h1);
        for (int i = 0; i < 8; i++) exp_pc[i] = 32'h1c000200 + 32'(4*i);
        exp_pc[8] = 32'h1c000300;
        out_ready_i = 1'b1;
        drive(2'b01, 32'h1c000300, 32'h0, 32'h13, 32'h0);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t3_drain%0d", i), 64'(out_pc_o), 64'(exp_pc[i]));
            tick();
            if (i == 0) idle();
        end
        check("t3_empty", 64'(out_valid_o), 64'h0);
        check("t3_icnt", instr_cnt_o, 64'd12);
        check("t3_idx", 64'(out_index_o), 64'd12);

        // chip enable low gates all lanes
        chip_enable_i = 1'b0;
        drive(2'b11, 32'h1c000400, 32'h1c000404, 32'h13, 32'h13);
        tick(); tick(); tick();
        check("t4_valid", 64'(out_valid_o), 64'h0);
        check("t4_cycle", cycle_cnt_o, 64'(exp_cyc));
        chip_enable_i = 1'b1;
        idle();

        // async reset with 5 entries queued
        out_ready_i = 1'b0;
        drive(2'b11, 32'h1c000600, 32'h1c000604, 32'h13, 32'h13); tick();
        drive(2'b11, 32'h1c000608, 32'h1c00060c, 32'h13, 32'h13); tick();
        drive(2'b10, 32'h0, 32'h1c000610, 32'h0, 32'h13); tick();
        idle();
        check("t6_queued", 64'(out_valid_o), 64'h1);
        check("t6_stall5", 64'(stall_o), 64'h0);
        #2 reset = 1'b1;
        #1;
        check("t6_valid", 64'(out_valid_o), 64'h0);
        check("t6_cycle", cycle_cnt_o, 64'h0);
        check("t6_icnt", instr_cnt_o, 64'h0);
        check("t6_idx", 64'(out_index_o), 64'h0);
        check("t6_ovf", 64'(overflow_o), 64'h0);
        #1 reset = 1'b0;
        exp_cyc = 0;

        // trap capture and freeze
        out_ready_i = 1'b1;
        gpr_a0_i = 32'h2a;
        drive(2'b11, 32'h1c000100, 32'h1c000104, 32'h80000000, 32'h13);
        tick(); idle();
        check("t5_head", 64'(out_instr_o), 64'h80000000);
        tick();
        trapped = 1'b1;
        check("t5_trap", 64'(trap_valid_o), 64'h1);
        check("t5_tpc", 64'(trap_pc_o), 64'h1c000100);
        check("t5_code", 64'(trap_code_o), 64'h2a);
        check("t5_icnt", instr_cnt_o, 64'h1);
        check("t5_cycle", cycle_cnt_o, 64'(exp_cyc));
        gpr_a0_i = 32'h99;
        drive(2'b11, 32'h1c000500, 32'h1c000504, 32'h13, 32'h13);
        tick(); idle();
        check("t5_ignored", 64'(out_valid_o), 64'h0);
        check("t5_icnt_frz", instr_cnt_o, 64'h1);
        check("t5_idx", 64'(out_index_o), 64'h2);
        check("t5_no_ovf", 64'(overflow_o), 64'h0);
        check("t5_code_hold", 64'(trap_code_o), 64'h2a);
        tick();
        check("t5_cycle_frz", cycle_cnt_o, 64'(exp_cyc));

        #3 reset = 1'b1;
        #1;
        check("t6_trap_clr", 64'(trap_valid_o), 64'h0);
        check("t6_tpc_clr", 64'(trap_pc_o), 64'h0);
        check("t6_code_clr", 64'(trap_code_o), 64'h0);
        check("t6_cycle_clr", cycle_cnt_o, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
